tama_input_ctrl: RTL and testbench

//  Front-end input stage for the Tamagotchi state FSM. Synchronises and debounces two raw board

---
 rtl/tama_input_ctrl.sv | 148 ++++++++++++++
 tb/tb_tama_input_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tama_input_ctrl.sv
// Button front end for the pet stat FSM: synchronise and debounce select/action buttons,
// rotate the action selector, and emit one-cycle action or game-reset pulses with a cooldown.
module tama_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 150_000_000,
  parameter int COOLDOWN_CYCLES = 50_000_000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       btn_select,
  input  logic       btn_action,
  output logic [1:0] sel_action,
  output logic       feed_pulse,
  output logic       sleep_pulse,
  output logic       play_pulse,
  output logic       heal_pulse,
  output logic       game_reset_pulse,
  output logic       busy
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int CD_W   = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic              REL_LVL   = (BTN_ACTIVE_LOW != 0);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [CD_W-1:0]   CD_LAST   = CD_W'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD, COOLDOWN} state_t;

  // Bit 0 is the select button, bit 1 the action button.
  logic [1:0]      rawBtn, sync1, sync2, pressed, clean, cleanD, rise, fall;
  logic [DB_W-1:0] dbCnt [2];

  state_t            state, stateNxt;
  logic [HOLD_W-1:0] holdCnt, holdCntNxt;
  logic [CD_W-1:0]   cdCnt, cdCntNxt;
  logic [1:0]        selLat, selLatNxt;
  logic [4:0]        pulse, pulseNxt;

  assign rawBtn  = {btn_action, btn_select};
  assign pressed = sync2 ^ {2{REL_LVL}};
  assign rise    = clean & ~cleanD;
  assign fall    = ~clean & cleanD;

  // Any cycle where synced and clean levels agree restarts the count, so bounces never flip.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      sync1    <= {2{REL_LVL}};
      sync2    <= {2{REL_LVL}};
      clean    <= '0;
      cleanD   <= '0;
      dbCnt[0] <= '0;
      dbCnt[1] <= '0;
    end else begin
      sync1  <= rawBtn;
      sync2  <= sync1;
      cleanD <= clean;
      for (int i = 0; i < 2; i++) begin
        if (pressed[i] != clean[i]) begin
          if (dbCnt[i] == DB_LAST) begin
            clean[i] <= ~clean[i];
            dbCnt[i] <= '0;
          end else begin
            dbCnt[i] <= dbCnt[i] + 1'b1;
          end
        end else begin
          dbCnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      sel_action <= 2'd0;
    end else if (rise[0]) begin
      sel_action <= sel_action + 2'd1;
    end
  end

  always_comb begin
    stateNxt   = state;
    holdCntNxt = holdCnt;
    cdCntNxt   = cdCnt;
    selLatNxt  = selLat;
    pulseNxt   = '0;
    unique case (state)
      IDLE: begin
        if (rise[1]) begin
          stateNxt   = PRESSED;
          holdCntNxt = '0;
          selLatNxt  = sel_action;
        end
      end
      PRESSED: begin
        if (holdCnt != '1) holdCntNxt = holdCnt + 1'b1;
        if (fall[1] && (holdCnt < LONG_LAST)) begin
          stateNxt         = COOLDOWN;
          cdCntNxt         = '0;
          pulseNxt[selLat] = 1'b1;
        end else if (holdCnt == LONG_LAST) begin
          // A release landing exactly on the threshold still counts as a long press.
          stateNxt    = fall[1] ? COOLDOWN : LONG_HELD;
          cdCntNxt    = '0;
          pulseNxt[4] = 1'b1;
        end
      end
      LONG_HELD: begin
        if (fall[1]) begin
          stateNxt = COOLDOWN;
          cdCntNxt = '0;
        end
      end
      COOLDOWN: begin
        if (cdCnt == CD_LAST) begin
          stateNxt = IDLE;
          cdCntNxt = '0;
        end else if (cdCnt != '1) begin
          cdCntNxt = cdCnt + 1'b1;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state   <= IDLE;
      holdCnt <= '0;
      cdCnt   <= '0;
      selLat  <= 2'd0;
      pulse   <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= stateNxt;
      holdCnt <= holdCntNxt;
      cdCnt   <= cdCntNxt;
      selLat  <= selLatNxt;
      pulse   <= pulseNxt;
      busy    <= (stateNxt != IDLE);
    end
  end

  assign {game_reset_pulse, heal_pulse, play_pulse, sleep_pulse, feed_pulse} = pulse;

endmodule

// File: tb/tb_tama_input_ctrl.sv
// Scoreboard bench for tama_input_ctrl with short debounce/long/cooldown windows.
`timescale 1ns/1ps
module tb_tama_input_ctrl;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int CD   = 10;
  // Raw change driven just after a posedge, seen at negedges: 2 sync + DEB + 1 register, +1 negedge.
  localparam int LAT  = 2 + DEB + 1 + 1;
  localparam logic PR = 1'b0;
  localparam logic RL = 1'b1;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       btn_select = RL;
  logic       btn_action = RL;
  logic [1:0] sel_action;
  logic       feed_pulse, sleep_pulse, play_pulse, heal_pulse, game_reset_pulse, busy;

  tama_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .COOLDOWN_CYCLES(CD), .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .Reset(Reset), .btn_select(btn_select), .btn_action(btn_action),
    .sel_action(sel_action), .feed_pulse(feed_pulse), .sleep_pulse(sleep_pulse),
    .play_pulse(play_pulse), .heal_pulse(heal_pulse), .game_reset_pulse(game_reset_pulse),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int         nChecks = 0;
  int         nPass = 0;
  int         busyCyc = 0;
  logic [2:0] expQ[$];   // 1 feed, 2 sleep, 3 play, 4 heal, 5 game reset
  logic [1:0] expSel = 2'd0;

  always @(negedge clk) begin : monitor
    int nHigh;
    logic [2:0] code, want;
    nHigh = 0;
    code = 3'd0;
    if (feed_pulse === 1'b1)       begin nHigh++; code = 3'd1; end
    if (sleep_pulse === 1'b1)      begin nHigh++; code = 3'd2; end
    if (play_pulse === 1'b1)       begin nHigh++; code = 3'd3; end
    if (heal_pulse === 1'b1)       begin nHigh++; code = 3'd4; end
    if (game_reset_pulse === 1'b1) begin nHigh++; code = 3'd5; end
    if (busy === 1'b1) busyCyc++;
    if (nHigh != 0) begin
      nChecks++;
      if (nHigh > 1) $display("FAIL pulse_onehot: %0d pulses high, at most 1 required", nHigh);
      else nPass++;
      nChecks++;
      if (expQ.size() == 0) begin
        $display("FAIL unexpected_pulse: got code %0d at %0t, none expected", code, $time);
      end else begin
        want = expQ.pop_front();
        if (code !== want) $display("FAIL pulse_kind: got code %0d, required %0d", code, want);
        else nPass++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitBusy(input logic lvl, input int maxN, output int n);
    n = -1;
    for (int k = 1; k <= maxN; k++) begin
      @(negedge clk);
      if (busy === lvl) begin n = k; return; end
    end
  endtask

  task automatic waitPulse(input int maxN, output int n);
    n = -1;
    for (int k = 1; k <= maxN; k++) begin
      @(negedge clk);
      if ((feed_pulse | sleep_pulse | play_pulse | heal_pulse | game_reset_pulse) === 1'b1) begin
        n = k; return;
      end
    end
  endtask

  task automatic pressSelect();
    btn_select = PR;
    tick(7);
    btn_select = RL;
    tick(7);
    expSel = expSel + 2'd1;
  endtask

  task automatic test_reset();
    int n, snap;
    Reset = 1'b0;
    btn_action = PR;
    tick(3);
    @(negedge clk);
    nChecks++;
    if ({sel_action, feed_pulse, sleep_pulse, play_pulse, heal_pulse, game_reset_pulse, busy} !== 8'd0)
      $display("FAIL reset_outputs: got %b, required 00000000",
               {sel_action, feed_pulse, sleep_pulse, play_pulse, heal_pulse, game_reset_pulse, busy});
    else nPass++;
    snap = busyCyc;
    Reset = 1'b1;
    tick(2);
    btn_action = RL;
    tick(12);
    nChecks++;
    if (busyCyc - snap !== 0) $display("FAIL reset_held_press: busy cycles %0d, required 0", busyCyc - snap);
    else nPass++;
    btn_action = PR;
    waitBusy(1'b1, 30, n);
    nChecks++;
    if (n !== LAT) $display("FAIL feed_busy_latency: got %0d, required %0d", n, LAT);
    else nPass++;
    tick(3);
    expQ.push_back(3'd1);
    btn_action = RL;
    waitPulse(30, n);
    nChecks++;
    if (n !== LAT) $display("FAIL feed_pulse_latency: got %0d, required %0d", n, LAT);
    else nPass++;
    waitBusy(1'b0, 30, n);
    nChecks++;
    if (n !== CD) $display("FAIL feed_cooldown: busy after pulse %0d, required %0d", n, CD);
    else nPass++;
  endtask

  task automatic test_select();
    for (int i = 0; i < 4; i++) begin
      pressSelect();
      @(negedge clk);
      nChecks++;
      if (sel_action !== expSel) $display("FAIL select_step%0d: got %0d, required %0d", i, sel_action, expSel);
      else nPass++;
    end
  endtask

  task automatic test_play();
    int n;
    pressSelect();
    pressSelect();
    btn_action = PR;
    waitBusy(1'b1, 30, n);
    nChecks++;
    if (n !== LAT) $display("FAIL play_busy_latency: got %0d, required %0d", n, LAT);
    else nPass++;
    tick(8);
    expQ.push_back(3'd3);
    btn_action = RL;
    waitPulse(30, n);
    nChecks++;
    if (n !== LAT || play_pulse !== 1'b1)
      $display("FAIL play_pulse: latency %0d play %b, required %0d and 1", n, play_pulse, LAT);
    else nPass++;
    waitBusy(1'b0, 30, n);
    nChecks++;
    if (n !== CD) $display("FAIL play_cooldown: busy after pulse %0d, required %0d", n, CD);
    else nPass++;
  endtask

  task automatic test_bounce();
    int lens[7] = '{1, 2, 3, 3, 2, 1, 3};
    int snap;
    snap = busyCyc;
    foreach (lens[i]) begin
      btn_action = PR;
      tick(lens[i]);
      btn_action = RL;
      tick(1);
    end
    tick(12);
    nChecks++;
    if (busyCyc - snap !== 0) $display("FAIL bounce_filtered: busy cycles %0d, required 0", busyCyc - snap);
    else nPass++;
  endtask

  task automatic test_long_press();
    int n;
    btn_action = PR;
    waitBusy(1'b1, 30, n);
    expQ.push_back(3'd5);
    waitPulse(40, n);
    nChecks++;
    if (n !== LONG || game_reset_pulse !== 1'b1)
      $display("FAIL long_press: hold %0d grp %b, required %0d and 1", n, game_reset_pulse, LONG);
    else nPass++;
    tick(10);
    nChecks++;
    if (busy !== 1'b1) $display("FAIL long_held_busy: got %b, required 1", busy);
    else nPass++;
    btn_action = RL;
    waitBusy(1'b0, 40, n);
    nChecks++;
    if (n !== LAT + CD) $display("FAIL long_release_cooldown: got %0d, required %0d", n, LAT + CD);
    else nPass++;
    nChecks++;
    if (expQ.size() !== 0) $display("FAIL long_queue: %0d pulses missing, required 0", expQ.size());
    else nPass++;
  endtask

  task automatic test_cooldown_and_sel();
    int n, snap;
    // Second press lands entirely inside the cooldown window.
    btn_action = PR;
    waitBusy(1'b1, 30, n);
    tick(3);
    expQ.push_back(3'd3);
    btn_action = RL;
    waitPulse(30, n);
    tick(1);
    btn_action = PR;
    tick(7);
    btn_action = RL;
    waitBusy(1'b0, 30, n);
    nChecks++;
    if (n !== 3) $display("FAIL cooldown_ignore_exit: got %0d, required 3", n);
    else nPass++;
    tick(1);
    snap = busyCyc;
    tick(15);
    nChecks++;
    if (busyCyc - snap !== 0) $display("FAIL cooldown_ignore: busy cycles %0d, required 0", busyCyc - snap);
    else nPass++;

    // Select press and action release on the same cycle.
    btn_action = PR;
    waitBusy(1'b1, 30, n);
    tick(3);
    expQ.push_back(3'd1 + 3'(expSel));
    btn_action = RL;
    btn_select = PR;
    expSel = expSel + 2'd1;
    waitPulse(30, n);
    nChecks++;
    if (n !== LAT || sel_action !== expSel)
      $display("FAIL simul_sel_release: latency %0d sel %0d, required %0d and %0d", n, sel_action, LAT, expSel);
    else nPass++;
    tick(5);
    btn_select = RL;
    waitBusy(1'b0, 30, n);

    // Selection changes while the action is held; the pulse uses the press-time selection.
    btn_action = PR;
    waitBusy(1'b1, 30, n);
    btn_select = PR;
    tick(5);
    btn_select = RL;
    tick(3);
    expQ.push_back(3'd1 + 3'(expSel));
    expSel = expSel + 2'd1;
    btn_action = RL;
    waitPulse(30, n);
    nChecks++;
    if (n !== LAT || sel_action !== expSel)
      $display("FAIL sel_during_press: latency %0d sel %0d, required %0d and %0d", n, sel_action, LAT, expSel);
    else nPass++;
    waitBusy(1'b0, 30, n);

    // Reset while PRESSED aborts without a pulse.
    pressSelect();
    btn_action = PR;
    waitBusy(1'b1, 30, n);
    tick(2);
    Reset = 1'b0;
    tick(2);
    btn_action = RL;
    tick(1);
    nChecks++;
    if (busy !== 1'b0 || sel_action !== 2'd0)
      $display("FAIL reset_in_pressed: busy %b sel %0d, required 0 and 0", busy, sel_action);
    else nPass++;
    expSel = 2'd0;
    Reset = 1'b1;
    snap = busyCyc;
    tick(20);
    nChecks++;
    if (busyCyc - snap !== 0 || expQ.size() !== 0)
      $display("FAIL reset_no_pulse: busy cycles %0d queue %0d, required 0 and 0", busyCyc - snap, expQ.size());
    else nPass++;
  endtask

  initial begin
    test_reset();
    test_select();
    test_play();
    test_bounce();
    test_long_press();
    test_cooldown_and_sel();
    tick(5);
    nChecks++;
    if (expQ.size() !== 0) $display("FAIL final_queue: %0d pulses never seen, required 0", expQ.size());
    else nPass++;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
